// File: rtl/stopwatch_mode_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_mode_controller_pkg
//  Purpose  : Shared definitions for the stopwatch mode controller: FSM state
//             encodings, state width and button index map.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package stopwatch_mode_controller_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_RUN_UP   = 3'd1,
    ST_RUN_DOWN = 3'd2,
    ST_PAUSED   = 3'd3,
    ST_LIMIT    = 3'd4
  } state_t;

  // Bit positions of the buttons inside the internal press-event vector.
  localparam int NUM_BTN  = 5;
  localparam int BTN_CLR  = 0;
  localparam int BTN_STOP = 1;
  localparam int BTN_UP   = 2;
  localparam int BTN_DOWN = 3;
  localparam int BTN_LAP  = 4;

endpackage : stopwatch_mode_controller_pkg
`default_nettype wire

// File: rtl/stopwatch_mode_controller_button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : button_debouncer
//  Purpose  : Synchronises one raw push-button, filters it with a stability
//             counter and emits a single-cycle pulse on each debounced press.
//  Ports    : clk       - system clock
//             rst       - synchronous active-high reset
//             btn_raw   - asynchronous raw button level
//             press     - one-cycle pulse on debounced rising edge
//  Revision : 1.0 - initial release
// ============================================================================
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEBOUNCE_WIDTH  = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam logic [DEBOUNCE_WIDTH-1:0] CNT_LAST = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                      sync1;
  logic                      sync2;
  logic                      level;
  logic                      level_d;
  logic [DEBOUNCE_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= level;
      // Registered edge detect: keeps the pulse one cycle behind the level
      // flip so every consumer sees a clean, flop-driven event.
      press   <= level & ~level_d;
      if (sync2 != level) begin
        // The flip happens on the cycle that would make the disagreement
        // count equal DEBOUNCE_CYCLES.
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt   <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule : button_debouncer
`default_nettype wire

// File: rtl/stopwatch_mode_controller.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_mode_controller
//  Purpose  : Debounces the five stopwatch buttons and runs the mode FSM that
//             drives the counter's stop/direction/clear controls, the mode
//             LEDs and the lap-hold (display freeze) flag.
//  Ports    : Clk, Reset                 - clock, sync active-high reset
//             BtnClear/Stop/Up/Down/Lap  - raw asynchronous buttons
//             LimitReachedFlag           - counter at its terminal value
//             StopMode, UpDownMode       - counter controls
//             CounterReset               - one-cycle counter clear pulse
//             LapHold                    - display freeze request
//             ModeOutput0/1              - LEDs: running up / running down
//             State                      - current FSM state encoding
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_mode_controller
  import stopwatch_mode_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEBOUNCE_WIDTH  = 5
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               BtnClear,
  input  logic               BtnStop,
  input  logic               BtnUp,
  input  logic               BtnDown,
  input  logic               BtnLap,
  input  logic               LimitReachedFlag,
  output logic               StopMode,
  output logic               UpDownMode,
  output logic               CounterReset,
  output logic               LapHold,
  output logic               ModeOutput0,
  output logic               ModeOutput1,
  output logic [STATE_W-1:0] State
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;

  assign btn_raw[BTN_CLR]  = BtnClear;
  assign btn_raw[BTN_STOP] = BtnStop;
  assign btn_raw[BTN_UP]   = BtnUp;
  assign btn_raw[BTN_DOWN] = BtnDown;
  assign btn_raw[BTN_LAP]  = BtnLap;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_debounce
    button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DEBOUNCE_WIDTH  (DEBOUNCE_WIDTH)
    ) u_debouncer (
      .clk     (Clk),
      .rst     (Reset),
      .btn_raw (btn_raw[i]),
      .press   (press[i])
    );
  end

  state_t state_q;
  state_t state_d;
  logic   updown_q;
  logic   updown_d;
  logic   lap_q;
  logic   lap_d;
  logic   creset_q;
  logic   creset_d;
  logic   running;

  assign running = (state_q == ST_RUN_UP) || (state_q == ST_RUN_DOWN);

  // State register together with the held/pulsed control outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      updown_q <= 1'b1;
      lap_q    <= 1'b0;
      creset_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      updown_q <= updown_d;
      lap_q    <= lap_d;
      creset_q <= creset_d;
    end
  end

  // Next-state logic. The if/else chain encodes event priority; only the
  // top-most active event is considered, so a lower event arriving in the
  // same cycle is dropped even when the winner has no effect.
  // The limit flag is a level, so it only counts as an event while running;
  // otherwise a counter parked at its limit would mask every button.
  always_comb begin
    state_d  = state_q;
    lap_d    = lap_q;
    creset_d = 1'b0;

    if (press[BTN_CLR]) begin
      state_d  = ST_IDLE;
      lap_d    = 1'b0;
      creset_d = 1'b1;
    end else if (running && LimitReachedFlag) begin
      state_d = ST_LIMIT;
    end else if (press[BTN_STOP]) begin
      if (running) begin
        state_d = ST_PAUSED;
      end
    end else if (press[BTN_UP]) begin
      unique case (state_q)
        ST_IDLE, ST_RUN_DOWN, ST_PAUSED: state_d = ST_RUN_UP;
        ST_LIMIT:                        if (!updown_q) state_d = ST_RUN_UP;
        default:                         state_d = state_q;
      endcase
    end else if (press[BTN_DOWN]) begin
      unique case (state_q)
        ST_IDLE, ST_RUN_UP, ST_PAUSED: state_d = ST_RUN_DOWN;
        ST_LIMIT:                      if (updown_q) state_d = ST_RUN_DOWN;
        default:                       state_d = state_q;
      endcase
    end else if (press[BTN_LAP]) begin
      if (running) begin
        lap_d = ~lap_q;
      end else if (state_q == ST_PAUSED) begin
        lap_d = 1'b0;
      end
    end

    // Direction follows the run state being entered; held everywhere else.
    updown_d = updown_q;
    if (state_d == ST_RUN_UP) begin
      updown_d = 1'b1;
    end else if (state_d == ST_RUN_DOWN) begin
      updown_d = 1'b0;
    end
  end

  // Output decode straight from registered state.
  always_comb begin
    StopMode     = !running;
    ModeOutput0  = (state_q == ST_RUN_UP);
    ModeOutput1  = (state_q == ST_RUN_DOWN);
    UpDownMode   = updown_q;
    LapHold      = lap_q;
    CounterReset = creset_q;
    State        = state_q;
  end

endmodule : stopwatch_mode_controller
`default_nettype wire
